// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: shares one router output link among NUM_IN input FIFOs.
// Round-robin choice between packets, wormhole lock until the tail flit,
// credit-based flow control toward the downstream buffer.
// Optional build macro: NOC_ARB_STATS_EN adds stall_cnt_o, a saturating count
// of cycles in which a request was pending but no credit was available.
module noc_output_arbiter #(
    parameter int NUM_IN  = 5,
    parameter int WIDTH   = 16,
    parameter int CREDITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN-1:0]       req_valid_i,
    input  logic [NUM_IN*WIDTH-1:0] req_data_i,
    output logic [NUM_IN-1:0]       shift_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    write_en_o,
    input  logic                    credit_return_i,
    output logic [NUM_IN-1:0]       grant_o,
    output logic                    busy_o
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [15:0]             stall_cnt_o
`endif
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CRD_W = $clog2(CREDITS + 1);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_IN - 1);
    localparam logic [CRD_W-1:0] CRD_MAX   = CRD_W'(CREDITS);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]  owner_reg, owner_next;
    logic [CRD_W-1:0]  credits_reg, credits_next;
    logic [WIDTH-1:0]  data_reg;
    logic              write_en_reg;

    logic [WIDTH-1:0]  head [NUM_IN];
    logic [PTR_W-1:0]  rr_sel;
    logic              rr_hit;
    logic [PTR_W-1:0]  sel;
    logic              has_req;
    logic              send;
    logic              sel_tail;

    // Unpack the flat FIFO-head bus into one word per port.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_head
            assign head[gi] = req_data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin scan: first requesting port starting at rr_ptr, wrapping.
    always_comb begin
        int idx;
        rr_sel = rr_ptr_reg;
        rr_hit = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!rr_hit && req_valid_i[PTR_W'(idx)]) begin
                rr_sel = PTR_W'(idx);
                rr_hit = 1'b1;
            end
        end
    end

    // Selected port, send decision and the one-hot strobes derived from it.
    always_comb begin
        sel      = (state_reg == LOCKED) ? owner_reg : rr_sel;
        has_req  = (state_reg == LOCKED) ? req_valid_i[owner_reg] : rr_hit;
        send     = !rst && (credits_reg != '0) && has_req;
        sel_tail = head[sel][WIDTH-1];
        shift_o  = '0;
        grant_o  = '0;
        if (send) begin
            shift_o[sel] = 1'b1;
        end
        if (state_reg == LOCKED) begin
            grant_o[owner_reg] = 1'b1;
        end else if (send) begin
            grant_o[sel] = 1'b1;
        end
    end

    // Next-state logic: lock on a non-tail head flit, release on the tail.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        if (send) begin
            if (sel_tail) begin
                state_next  = IDLE;
                rr_ptr_next = (sel == LAST_PORT) ? '0 : sel + PTR_W'(1);
            end else begin
                state_next = LOCKED;
                owner_next = sel;
            end
        end
    end

    // Credit arithmetic; a simultaneous send and return cancel out.
    always_comb begin
        credits_next = credits_reg;
        if (send && !credit_return_i) begin
            credits_next = credits_reg - CRD_W'(1);
        end else if (!send && credit_return_i && credits_reg != CRD_MAX) begin
            credits_next = credits_reg + CRD_W'(1);
        end
    end

    // FSM, round-robin pointer, owner and credit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            credits_reg <= CRD_MAX;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            owner_reg   <= owner_next;
            credits_reg <= credits_next;
        end
    end

    // Output link register: one cycle from FIFO head to the link.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg     <= '0;
            write_en_reg <= 1'b0;
        end else begin
            write_en_reg <= send;
            if (send) begin
                data_reg <= head[sel];
            end
        end
    end

    // A credit return with nothing outstanding means downstream misbehaved.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(credit_return_i && credits_reg == CRD_MAX));
        end
    end

    assign data_o     = data_reg;
    assign write_en_o = write_en_reg;
    assign busy_o     = (state_reg == LOCKED);

`ifdef NOC_ARB_STATS_EN
    logic [15:0] stall_cnt_reg;

    // Count cycles a request waits only because the credit counter is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (has_req && credits_reg == '0 && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Testbench for noc_output_arbiter: bench-side input FIFOs feed the DUT, a
// queue-based reference model predicts every pop and link flit, and a monitor
// compares each link write against the scoreboard queue.
module tb_noc_output_arbiter;

    localparam int N = 5;
    localparam int W = 16;
    localparam int C = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   shift;
    logic [W-1:0]   data;
    logic           wen;
    logic           cret;
    logic [N-1:0]   grant;
    logic           busy;
`ifdef NOC_ARB_STATS_EN
    logic [15:0]    stall_cnt;
`endif

    always #5 clk = ~clk;

    noc_output_arbiter #(.NUM_IN(N), .WIDTH(W), .CREDITS(C)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .shift_o         (shift),
        .data_o          (data),
        .write_en_o      (wen),
        .credit_return_i (cret),
        .grant_o         (grant),
        .busy_o          (busy)
`ifdef NOC_ARB_STATS_EN
        ,
        .stall_cnt_o     (stall_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] fifo_q [N][$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_exp;

    // Reference model state: owner = -1 when no packet holds the link.
    int owner       = -1;
    int rr          = 0;
    int ds_cnt      = 0;
    int stall_model = 0;
    int wen_count   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every link write must match the oldest predicted flit.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            wen_count++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL link_write: got flit %0h expected no write", data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("link_flit", 32'(data), 32'(mon_exp));
            end
        end
    end

    // One clock of normal operation; ret requests a credit return if one is owed.
    task automatic drive(input bit ret);
        int  s;
        int  p;
        int  credits;
        bit  has;
        bit  snd;
        bit  eret;
        int  exp_shift;
        int  exp_grant;
        logic [W-1:0] f;
        @(negedge clk);
        eret = ret && (ds_cnt > 0);
        rst  = 1'b0;
        cret = eret;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (fifo_q[i].size() > 0);
            req_data[i*W +: W] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : W'($urandom);
        end
        #1;
        credits = C - ds_cnt;
        has = 1'b0;
        s   = 0;
        if (owner >= 0) begin
            s   = owner;
            has = (fifo_q[s].size() > 0);
        end else begin
            for (int k = 0; k < N; k++) begin
                p = (rr + k) % N;
                if (!has && fifo_q[p].size() > 0) begin
                    has = 1'b1;
                    s   = p;
                end
            end
        end
        snd       = has && (credits > 0);
        exp_shift = snd ? (1 << s) : 0;
        exp_grant = (owner >= 0) ? (1 << owner) : exp_shift;
        chk("shift_o", 32'(shift), exp_shift);
        chk("grant_o", 32'(grant), exp_grant);
        chk("busy_o", 32'(busy), (owner >= 0) ? 1 : 0);
`ifdef NOC_ARB_STATS_EN
        chk("stall_cnt_o", 32'(stall_cnt), stall_model);
`endif
        @(posedge clk);
        if (snd) begin
            f = fifo_q[s].pop_front();
            exp_q.push_back(f);
            if (f[W-1]) begin
                owner = -1;
                rr    = (s + 1) % N;
            end else begin
                owner = s;
            end
        end
        if (has && credits == 0 && stall_model < 65535) begin
            stall_model++;
        end
        ds_cnt = ds_cnt + (snd ? 1 : 0) - (eret ? 1 : 0);
    endtask

    // Two-cycle reset with every port requesting; bench FIFOs are flushed.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cret      = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = W'($urandom);
            fifo_q[i].delete();
        end
        owner       = -1;
        rr          = 0;
        ds_cnt      = 0;
        stall_model = 0;
        #1;
        chk("shift_o_in_reset", 32'(shift), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("shift_o_in_reset", 32'(shift), 0);
        chk("write_en_o_in_reset", 32'(wen), 0);
        chk("grant_o_in_reset", 32'(grant), 0);
        chk("busy_o_in_reset", 32'(busy), 0);
`ifdef NOC_ARB_STATS_EN
        chk("stall_cnt_o_in_reset", 32'(stall_cnt), 0);
`endif
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int p;
        int len;
        bit any;
        logic [W-1:0] f;
        rst       = 1'b1;
        cret      = 1'b0;
        req_valid = '0;
        req_data  = '0;

        do_reset();

        // Two single-flit packets: port 0 then port 2, pointer ends at 3.
        fifo_q[0].push_back(16'h8001);
        fifo_q[2].push_back(16'h8002);
        repeat (4) drive(1'b0);
        // Pointer at 3: port 3 must win over port 0.
        fifo_q[0].push_back(16'h8010);
        fifo_q[3].push_back(16'h8013);
        repeat (4) drive(1'b1);

        // Wormhole: port 1's three flits all precede port 3's flit.
        fifo_q[1].push_back(16'h0001);
        fifo_q[1].push_back(16'h0002);
        fifo_q[1].push_back(16'h8003);
        fifo_q[3].push_back(16'h8004);
        repeat (6) drive(1'b1);

        // Credit exhaustion: 5 flits then stall; one return releases one flit.
        do_reset();
        for (int k = 0; k < 8; k++) fifo_q[4].push_back(16'h0040 + 16'(k));
        base = wen_count;
        repeat (12) drive(1'b0);
        chk("flits_before_stall", 32'(wen_count - base), 5);
        base = wen_count;
        drive(1'b1);
        repeat (4) drive(1'b0);
        chk("flits_after_one_return", 32'(wen_count - base), 1);

        // Send and return together at credits=1, then another send.
        do_reset();
        for (int k = 0; k < 5; k++) fifo_q[0].push_back(16'h0050 + 16'(k));
        fifo_q[0].push_back(16'h8055);
        repeat (4) drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        repeat (8) drive(1'b1);

        // Reset mid-packet with port 2 owning the link and some stalls counted.
        do_reset();
        for (int k = 0; k < 7; k++) fifo_q[2].push_back(16'h0020 + 16'(k));
        repeat (7) drive(1'b0);
        do_reset();
        for (int k = 0; k < 6; k++) fifo_q[1].push_back(16'h8060 + 16'(k));
        base = wen_count;
        repeat (8) drive(1'b0);
        chk("credits_restored_after_reset", 32'(wen_count - base), 5);

        // Randomised traffic: frequent returns, then scarce returns.
        do_reset();
        for (int cyc = 0; cyc < 1600; cyc++) begin
            if ($urandom_range(3) == 0) begin
                p = $urandom_range(N - 1);
                if (fifo_q[p].size() < 8) begin
                    len = $urandom_range(4, 1);
                    for (int k = 0; k < len; k++) begin
                        f = W'($urandom);
                        f[W-1] = (k == len - 1);
                        fifo_q[p].push_back(f);
                    end
                end
            end
            if (cyc < 800) drive($urandom_range(3) != 0);
            else           drive($urandom_range(4) == 0);
        end

        // Drain everything still queued.
        for (int cyc = 0; cyc < 400; cyc++) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) if (fifo_q[i].size() > 0) any = 1'b1;
            if (!any) break;
            drive(1'b1);
        end
        repeat (3) drive(1'b1);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
